// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS core.
// Opcode/funct encodings, FSM state type and a sign-extension helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } stateT;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_multicycle_core_regfile.sv
// Architectural register file: two combinational reads, one synchronous write.
// R0 and any index at or beyond NREGS read as zero and ignore writes.
module mc_regfile
  import mips_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clkIn,
  input  logic        rstnIn,
  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  output logic [31:0] rdDataA,
  output logic [31:0] rdDataB,
  input  logic        wrEn,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [31:0] regs [NREGS];

  function automatic logic usable(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < NREGS_L);
  endfunction

  assign rdDataA = usable(rdAddrA) ? regs[rdAddrA[IDX_W-1:0]] : 32'd0;
  assign rdDataB = usable(rdAddrB) ? regs[rdAddrB[IDX_W-1:0]] : 32'd0;

  // Register storage with asynchronous clear.
  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wrEn && usable(wrAddr)) begin
      regs[wrAddr[IDX_W-1:0]] <= wrData;
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one ALU, one req/ack memory port, halt/trap.
// The FSM walks FETCH/DECODE/EXEC/MEM/WB; memory strobes are a decode of state.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clkIn,
  input  logic              rstnIn,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  input  logic              memAck,
  output logic [31:0]       pcOut,
  output logic              halted,
  output logic              trap
);

  stateT       state;
  logic [31:0] pc, ir, regA, regB, aluOut, mdr;
  logic        trapR;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] rdA, rdB, aluRes;
  logic        aluBad, opKnown;
  logic        rfWe;
  logic [4:0]  rfWAddr;
  logic [31:0] rfWData;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign imm16 = ir[15:0];

  mc_regfile #(.NREGS(NREGS)) uRegFile (
    .clkIn   (clkIn),
    .rstnIn  (rstnIn),
    .rdAddrA (rs),
    .rdAddrB (rt),
    .rdDataA (rdA),
    .rdDataB (rdB),
    .wrEn    (rfWe),
    .wrAddr  (rfWAddr),
    .wrData  (rfWData)
  );

  // Opcode legality check used in DECODE.
  always_comb begin
    opKnown = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: opKnown = 1'b1;
      default: opKnown = 1'b0;
    endcase
  end

  // Shared ALU: R-type by funct, everything else is base + sign-extended offset.
  always_comb begin
    aluRes = 32'd0;
    aluBad = 1'b0;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   aluRes = regA + regB;
        F_SUB:   aluRes = regA - regB;
        F_AND:   aluRes = regA & regB;
        F_OR:    aluRes = regA | regB;
        F_SLT:   aluRes = {31'd0, ($signed(regA) < $signed(regB))};
        default: aluBad = 1'b1;
      endcase
    end else begin
      aluRes = regA + sext16(imm16);
    end
  end

  // Write-back source and destination selection.
  always_comb begin
    rfWe    = (state == WB);
    rfWAddr = rt;
    rfWData = aluOut;
    if (op == OP_RTYPE) begin
      rfWAddr = rd;
    end else begin
      rfWAddr = rt;
    end
    if (op == OP_LW) begin
      rfWData = mdr;
    end else begin
      rfWData = aluOut;
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= 32'd0;
      regA   <= 32'd0;
      regB   <= 32'd0;
      aluOut <= 32'd0;
      mdr    <= 32'd0;
      trapR  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (memAck) begin
            ir    <= memRData;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          regA   <= rdA;
          regB   <= rdB;
          aluOut <= pc + (sext16(imm16) << 2);
          if (op == OP_HALT) begin
            state <= HALT;
          end else if (!opKnown) begin
            trapR <= 1'b1;
            state <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_RTYPE: begin
              if (aluBad) begin
                trapR <= 1'b1;
                state <= HALT;
              end else begin
                aluOut <= aluRes;
                state  <= WB;
              end
            end
            OP_ADDI: begin
              aluOut <= aluRes;
              state  <= WB;
            end
            OP_LW, OP_SW: begin
              aluOut <= aluRes;
              if (aluRes[1:0] != 2'b00) begin
                trapR <= 1'b1;
                state <= HALT;
              end else begin
                state <= MEM;
              end
            end
            OP_BEQ: begin
              if (regA == regB) pc <= aluOut;
              state <= FETCH;
            end
            OP_J: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= FETCH;
            end
            default: begin
              trapR <= 1'b1;
              state <= HALT;
            end
          endcase
        end
        MEM: begin
          if (memAck) begin
            if (op == OP_LW) begin
              mdr   <= memRData;
              state <= WB;
            end else begin
              state <= FETCH;
            end
          end
        end
        WB:   state <= FETCH;
        HALT: state <= HALT;
        default: begin
          // Corrupted state encoding: stop rather than run on garbage.
          trapR <= 1'b1;
          state <= HALT;
        end
      endcase
    end
  end

  // Memory port strobes decoded from the registered state.
  always_comb begin
    memReq   = 1'b0;
    memWe    = 1'b0;
    memAddr  = {ADDR_W{1'b0}};
    memWData = 32'd0;
    if (state == FETCH) begin
      memReq  = 1'b1;
      memAddr = pc[ADDR_W-1:0];
    end else if (state == MEM) begin
      memReq   = 1'b1;
      memWe    = (op == OP_SW);
      memAddr  = aluOut[ADDR_W-1:0];
      memWData = regB;
    end else begin
      memReq = 1'b0;
    end
  end

  assign pcOut  = pc;
  assign halted = (state == HALT);
  assign trap   = trapR;

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath: one shared ALU, one unified external memory port, and an FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
- Memory port uses a req/ack handshake, so variable-latency RAM is tolerated.
- Adds halt and trap detection.
- Sits as the CPU top; memory and testbench attach to the bus ports.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, number of architectural registers (power of 2, 8..32). Index >= NREGS reads 0; writes to it are dropped.
- ADDR_W, 32, width of memAddr. The PC/ALU address is truncated to the low ADDR_W bits.

Ports:
- clkIn  in  1  clock, rising edge.
- rstnIn  in  1  reset, asynchronous, active-low.
- memReq  out  1  memory request.
- memWe  out  1  1 = write (sw), 0 = read.
- memAddr  out  ADDR_W  byte address, word-aligned.
- memWData  out  32  store data.
- memRData  in  32  read data; valid when memAck=1.
- memAck  in  1  request completion.
- pcOut  out  32  current PC (debug).
- halted  out  1  core stopped (halt or trap).
- trap  out  1  stop caused by an illegal opcode/funct or a misaligned lw/sw.

Behaviour:
- Reset (async, rstnIn=0):
  - state=IDLE, PC=RESET_PC, all registers=0, IR/A/B/ALUOut/MDR=0.
  - memReq=0, memWe=0, memAddr=0, memWData=0, halted=0, trap=0.
- States: IDLE -> FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH; HALT is terminal until reset.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - memReq=1, memWe=0, memAddr=PC.
  - Wait while memAck=0.
  - On ack: IR<=memRData, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm16)<<2).
  - Opcode not in {00,23,2B,04,08,02,3F} -> HALT with trap=1.
  - Opcode 3F -> HALT with trap=0.
- EXEC:
  - R-type (op 00), by funct:
    - 20 add, 22 sub, 24 and, 25 or, 2A slt (signed compare, result 0/1).
    - Other funct -> HALT with trap=1.
    - ALUOut<=result, then WB.
  - addi (08): ALUOut<=A+sext(imm), then WB.
  - lw (23) / sw (2B): ALUOut<=A+sext(imm).
    - If the sum has bits [1:0]!=0 -> HALT with trap=1.
    - Otherwise go to MEM.
  - beq (04): if A==B then PC<=ALUOut. Go to FETCH.
  - j (02): PC<={PC[31:28], imm26, 2'b00}. Go to FETCH.
- MEM:
  - memReq=1, memAddr=ALUOut, memWe=(sw), memWData=B.
  - Hold all four stable until memAck.
  - sw: FETCH on ack.
  - lw: MDR<=memRData on ack, then WB.
- WB:
  - R-type writes R[rd]<=ALUOut.
  - addi writes R[rt]<=ALUOut.
  - lw writes R[rt]<=MDR.
  - Writes to R0 are ignored.
- Handshake rules:
  - memAck is sampled only in FETCH/MEM.
  - memReq is a decode of state and drops in the cycle after the ack.
  - An ack in the same cycle as the req is legal (zero-wait).
  - Stray acks outside FETCH/MEM are ignored.
- Cycle counts with zero-wait memory: R/addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- Arithmetic: 32-bit two's complement, wraps silently, no overflow exception. PC+4 wraps at 2^32.
- HALT: memReq=0, halted=1, trap held. PC and registers are frozen. Only reset exits.
- Reset mid-transaction: the request is abandoned immediately and the memory side must tolerate the dropped memReq.
- Register reads within the same instruction see writes from the previous instruction (WB completes before the next DECODE).

Decomposition:
- Package mips_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT.
  - Funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - State enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
- One sub-module, mc_regfile:
  - Parameter NREGS.
  - Two combinational read ports, one synchronous write port, async-reset to 0, R0 hardwired 0.

Test Plan:
- Zero-wait memory, program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt -> R3=12; halted=1, trap=0 at cycle 1+4+4+4+2; pcOut=0x10.
- sw $3,8($0) then lw $4,8($0), with memAck delayed 3 cycles on every access -> mem[8]=12, R4=12; memAddr/memWe/memWData stable throughout each wait.
- beq $1,$1,-1 with timeout, then beq $1,$2,+2 -> first loops back to its own address (PC repeats); second is not taken (PC+4).
- j 0x40 at PC 0x0 -> next fetch memAddr=0x100; slt with A=-1, B=1 -> 1.
- Opcode 0x3E, funct 0x3F, and lw $1,2($0) each -> halted=1, trap=1, memReq=0, no register write.
- rstnIn pulsed low during a MEM wait -> memReq=0 immediately, PC=RESET_PC, registers 0, IDLE then FETCH of RESET_PC; add $0,$1,$1 -> R0 stays 0.
